// File: rtl/rgb_mixer_if.sv
// Pin bundle between the caravel user wrapper and the RGB mixer: six encoder
// phases in, three PWM lines and the period sync pulse out.
interface rgb_mixer_if;
  logic enc0_a;
  logic enc0_b;
  logic enc1_a;
  logic enc1_b;
  logic enc2_a;
  logic enc2_b;
  logic pwm0_out;
  logic pwm1_out;
  logic pwm2_out;
  logic sync;

  modport master (
    output enc0_a, enc0_b, enc1_a, enc1_b, enc2_a, enc2_b,
    input  pwm0_out, pwm1_out, pwm2_out, sync
  );

  modport slave (
    input  enc0_a, enc0_b, enc1_a, enc1_b, enc2_a, enc2_b,
    output pwm0_out, pwm1_out, pwm2_out, sync
  );
endinterface

// File: rtl/rgb_mixer.sv
// Three-channel rotary-encoder RGB mixer with glitch-free PWM outputs.
// Define RGB_MIXER_DEBOUNCE_EN to insert a history-based debouncer after the synchronizers.
module rgb_mixer #(
  parameter int WIDTH         = 8,
  parameter int DEBOUNCE_HIST = 8
) (
  input  logic         clk,
  input  logic         reset,
  rgb_mixer_if.slave   bus
);

  localparam int NCH = 3;
  localparam int NIN = 2 * NCH;

  // Input bit 2*ch is phase A, bit 2*ch+1 is phase B of channel ch.
  logic [NIN-1:0] raw_in;
  assign raw_in = {bus.enc2_b, bus.enc2_a, bus.enc1_b, bus.enc1_a, bus.enc0_b, bus.enc0_a};

  logic [NIN-1:0] meta_q, meta_d;
  logic [NIN-1:0] syn_q, syn_d;
  logic [NIN-1:0] dec_in;

  always_comb begin
    meta_d = raw_in;
    syn_d  = meta_q;
  end

`ifdef RGB_MIXER_DEBOUNCE_EN
  logic [NIN-1:0][DEBOUNCE_HIST-1:0] hist_q, hist_d;
  logic [NIN-1:0]                    deb_q, deb_d;

  // Output only moves once the whole history agrees; mixed history holds.
  always_comb begin
    hist_d = hist_q;
    deb_d  = deb_q;
    for (int i = 0; i < NIN; i++) begin
      hist_d[i] = {hist_q[i][DEBOUNCE_HIST-2:0], syn_q[i]};
      if (&hist_q[i]) begin
        deb_d[i] = 1'b1;
      end else if (~|hist_q[i]) begin
        deb_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= '0;
      deb_q  <= '0;
    end else begin
      hist_q <= hist_d;
      deb_q  <= deb_d;
    end
  end

  assign dec_in = deb_q;
`else
  assign dec_in = syn_q;
`endif

  logic [NCH-1:0]            prev_a_q, prev_a_d;
  logic [NCH-1:0][WIDTH-1:0] level_q, level_d;

  // x1 decoding: only a rising A edge moves the level, B picks the direction.
  always_comb begin
    prev_a_d = prev_a_q;
    level_d  = level_q;
    for (int ch = 0; ch < NCH; ch++) begin
      prev_a_d[ch] = dec_in[2*ch];
      if (!prev_a_q[ch] && dec_in[2*ch]) begin
        if (dec_in[2*ch+1]) begin
          level_d[ch] = level_q[ch] - WIDTH'(1);
        end else begin
          level_d[ch] = level_q[ch] + WIDTH'(1);
        end
      end
    end
  end

  logic [WIDTH-1:0]          cnt_q, cnt_d;
  logic [NCH-1:0][WIDTH-1:0] duty_q, duty_d;
  logic [NCH-1:0]            pwm_q, pwm_d;
  logic                      sync_q, sync_d;
  logic                      wrap;

  // The compare at counter 0 already uses the freshly latched duty, so each
  // period starts cleanly with the new value.
  always_comb begin
    wrap   = (cnt_q == '0);
    cnt_d  = cnt_q + WIDTH'(1);
    duty_d = duty_q;
    pwm_d  = '0;
    sync_d = wrap;
    for (int ch = 0; ch < NCH; ch++) begin
      if (wrap) begin
        duty_d[ch] = level_q[ch];
      end
      pwm_d[ch] = (cnt_q < duty_d[ch]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q   <= '0;
      syn_q    <= '0;
      prev_a_q <= '0;
      level_q  <= '0;
      cnt_q    <= '0;
      duty_q   <= '0;
      pwm_q    <= '0;
      sync_q   <= 1'b0;
    end else begin
      meta_q   <= meta_d;
      syn_q    <= syn_d;
      prev_a_q <= prev_a_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      duty_q   <= duty_d;
      pwm_q    <= pwm_d;
      sync_q   <= sync_d;
    end
  end

  assign bus.pwm0_out = pwm_q[0];
  assign bus.pwm1_out = pwm_q[1];
  assign bus.pwm2_out = pwm_q[2];
  assign bus.sync     = sync_q;

endmodule

// File: tb/tb_rgb_mixer.sv
// Self-checking bench for rgb_mixer: encoder detents against a level model,
// observed through PWM high-time per period and sync spacing.
module tb_rgb_mixer;
  localparam int WIDTH  = 8;
  localparam int HIST   = 8;
  localparam int PERIOD = 1 << WIDTH;
  localparam int HOLD   = HIST + 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   exp_lvl [3];

  rgb_mixer_if bus ();

  rgb_mixer #(.WIDTH(WIDTH), .DEBOUNCE_HIST(HIST)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic set_enc(input int ch, input logic a, input logic b);
    case (ch)
      0: begin bus.enc0_a = a; bus.enc0_b = b; end
      1: begin bus.enc1_a = a; bus.enc1_b = b; end
      default: begin bus.enc2_a = a; bus.enc2_b = b; end
    endcase
  endtask

  // One full quadrature detent; clockwise means A rises while B is low.
  task automatic detent(input int ch, input bit cw);
    set_enc(ch, 1'b0, !cw);
    repeat (HOLD) @(negedge clk);
    set_enc(ch, 1'b1, !cw);
    repeat (HOLD) @(negedge clk);
    set_enc(ch, 1'b0, !cw);
    repeat (HOLD) @(negedge clk);
    set_enc(ch, 1'b0, 1'b0);
    repeat (HOLD) @(negedge clk);
    if (cw) exp_lvl[ch] = (exp_lvl[ch] + 1) % PERIOD;
    else    exp_lvl[ch] = (exp_lvl[ch] + PERIOD - 1) % PERIOD;
  endtask

  task automatic wait_sync(output int waited, output bit found);
    found  = 1'b0;
    waited = 0;
    for (int i = 0; i < 2 * PERIOD + 50; i++) begin
      @(negedge clk);
      if (bus.sync === 1'b1) begin
        found = 1'b1;
        break;
      end
      waited++;
    end
  endtask

  // Counts high cycles over one period starting at the current (sync) cycle.
  task automatic count_period(output int c0, output int c1, output int c2, output int ns);
    c0 = 0; c1 = 0; c2 = 0; ns = 0;
    for (int k = 0; k < PERIOD; k++) begin
      if (k > 0) @(negedge clk);
      c0 += int'(bus.pwm0_out === 1'b1);
      c1 += int'(bus.pwm1_out === 1'b1);
      c2 += int'(bus.pwm2_out === 1'b1);
      ns += int'(bus.sync === 1'b1);
    end
  endtask

  task automatic measure(input string tag, input int exp_wait);
    int  waited, c0, c1, c2, ns;
    bit  found;
    wait_sync(waited, found);
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s sync_timeout: no sync within bound", tag);
      return;
    end
    if (exp_wait >= 0) begin
      checks++;
      if (waited !== exp_wait) begin
        errors++;
        $display("FAIL %s sync_spacing: waited %0d cycles, expected %0d", tag, waited, exp_wait);
      end
    end
    count_period(c0, c1, c2, ns);
    checks += 4;
    if (c0 !== exp_lvl[0]) begin errors++; $display("FAIL %s pwm0_duty: got %0d expected %0d", tag, c0, exp_lvl[0]); end
    if (c1 !== exp_lvl[1]) begin errors++; $display("FAIL %s pwm1_duty: got %0d expected %0d", tag, c1, exp_lvl[1]); end
    if (c2 !== exp_lvl[2]) begin errors++; $display("FAIL %s pwm2_duty: got %0d expected %0d", tag, c2, exp_lvl[2]); end
    if (ns !== 1) begin errors++; $display("FAIL %s sync_per_period: got %0d expected 1", tag, ns); end
  endtask

  task automatic test_reset();
    for (int ch = 0; ch < 3; ch++) begin
      set_enc(ch, 1'b0, 1'b0);
      exp_lvl[ch] = 0;
    end
    reset = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({bus.pwm0_out, bus.pwm1_out, bus.pwm2_out, bus.sync} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0000",
               {bus.pwm0_out, bus.pwm1_out, bus.pwm2_out, bus.sync});
    end
    reset = 1'b0;
    measure("reset_p1", 0);
    measure("reset_p2", 0);
    measure("reset_p3", 0);
  endtask

  task automatic test_ch0_cw();
    for (int i = 0; i < 10; i++) detent(0, 1'b1);
    measure("ch0_cw10", -1);
  endtask

  task automatic test_ch1_wrap();
    detent(1, 1'b0);
    measure("ch1_underflow", -1);
    detent(1, 1'b1);
    measure("ch1_overflow", -1);
  endtask

  task automatic test_bounce();
    detent(2, 1'b1);
    detent(2, 1'b1);
    measure("ch2_level2", -1);
    set_enc(2, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    set_enc(2, 1'b0, 1'b0);
    repeat (HOLD * 2) @(negedge clk);
`ifndef RGB_MIXER_DEBOUNCE_EN
    exp_lvl[2] = (exp_lvl[2] + 1) % PERIOD;
`endif
    measure("ch2_bounce", -1);
  endtask

  task automatic test_mid_period();
    int  waited, c0, c1, c2, ns, old0;
    bit  found;
    old0 = exp_lvl[0];
    wait_sync(waited, found);
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL mid_sync_timeout: no sync within bound");
      return;
    end
    fork
      count_period(c0, c1, c2, ns);
      begin
        repeat (99) @(negedge clk);
        detent(0, 1'b1);
      end
    join
    checks++;
    if (c0 !== old0) begin
      errors++;
      $display("FAIL mid_current_period: pwm0 high %0d expected %0d", c0, old0);
    end
    measure("mid_next_period", 0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) begin
        detent(int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)));
      end
      measure("random", -1);
    end
  endtask

  task automatic test_reset_mid_op();
    int  waited, d;
    bit  found;
    for (int ch = 0; ch < 3; ch++) begin
      d = (50 - exp_lvl[ch] + PERIOD) % PERIOD;
      if (d <= PERIOD / 2) for (int i = 0; i < d; i++) detent(ch, 1'b1);
      else for (int i = 0; i < PERIOD - d; i++) detent(ch, 1'b0);
    end
    measure("all50", -1);
    wait_sync(waited, found);
    repeat (19) @(negedge clk);
    checks++;
    if ({bus.pwm0_out, bus.pwm1_out, bus.pwm2_out} !== 3'b111) begin
      errors++;
      $display("FAIL pre_reset_high: got %b expected 111", {bus.pwm0_out, bus.pwm1_out, bus.pwm2_out});
    end
    reset = 1'b1;
    @(negedge clk);
    for (int ch = 0; ch < 3; ch++) exp_lvl[ch] = 0;
    checks++;
    if ({bus.pwm0_out, bus.pwm1_out, bus.pwm2_out, bus.sync} !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %b expected 0000",
               {bus.pwm0_out, bus.pwm1_out, bus.pwm2_out, bus.sync});
    end
    @(negedge clk);
    reset = 1'b0;
    measure("post_reset", 0);
  endtask

  initial begin
    test_reset();
    test_ch0_cw();
    test_ch1_wrap();
    test_bounce();
    test_mid_period();
    test_random();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
